imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width; capacity 2**ADDR_W words.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, number of cycles the core reset is held after the last word is written.
REQ-003 SHALL have port clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a program load.
REQ-006 SHALL have port in_valid  input  1  the input word is valid.
REQ-007 SHALL have port in_data  input  32  instruction word.
REQ-008 SHALL have port in_last  input  1  marks the final word of the program.
REQ-009 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port im_we  output  1  instruction-memory write enable.
REQ-011 SHALL have port im_addr  output  ADDR_W  instruction-memory word address.
REQ-012 SHALL have port im_wdata  output  32  instruction-memory write data.
REQ-013 SHALL have port core_rst  output  1  drives rst_pc and rst_regFile of the core; active-high.
REQ-014 SHALL have port busy  output  1  a load is in progress.
REQ-015 SHALL have port done  output  1  the program is loaded and the core is released.
REQ-016 SHALL have port err  output  1  sticky overflow flag.
REQ-017 SHALL have port word_count  output  ADDR_W+1  number of words written by the current or last load.

Function
REQ-018 SHALL implement the states IDLE, LOAD, HOLD and RUN.
REQ-019 SHALL, in IDLE, move to LOAD when start=1, clearing word_count, the address counter, done and err.
REQ-020 SHALL drive in_ready=1 only in LOAD; a word transfers when in_valid and in_ready are both 1 in the same cycle.
REQ-021 SHALL, on each transfer, register im_we=1, im_addr=the address counter and im_wdata=in_data one cycle later, then increment the address counter and word_count (latency 1 cycle).
REQ-022 SHALL drive im_we=0 in every cycle that follows a cycle with no transfer.
REQ-023 SHALL, on a transfer with in_last=1, move to HOLD and load the hold counter with HOLD_CYCLES.
REQ-024 SHALL, if a transfer occurs when the address is 2**ADDR_W-1 and in_last=0: write that word, set err=1, drop all further words (in_ready=0) and move to HOLD.
REQ-025 SHALL NOT wrap im_addr past 2**ADDR_W-1 under any condition.
REQ-026 SHALL hold core_rst=1 in IDLE, LOAD and HOLD, and core_rst=0 only in RUN.
REQ-027 SHALL, in HOLD, decrement the hold counter each cycle and move to RUN in the cycle after it reaches 0; with HOLD_CYCLES=0, RUN follows HOLD after one cycle.
REQ-028 SHALL drive busy=1 in LOAD and HOLD, and done=1 only in RUN.
REQ-029 SHALL, in RUN, return to LOAD when start=1 (reload), asserting core_rst the next cycle and clearing the counters as in REQ-019.
REQ-030 SHALL ignore start while in LOAD or HOLD.
REQ-031 SHALL, when start=1 and rst=1 are in the same cycle, let rst win.

Reset
REQ-032 SHALL, on rst=1 at a clock edge (including mid-load), enter IDLE with core_rst=1, in_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0, word_count=0.
REQ-033 SHALL NOT alter instruction-memory contents already written when reset is applied.

Configuration
REQ-034 SHALL, when macro IMEM_LOADER_CHECKSUM_EN is defined, add output checksum (32 bits): the XOR of all written words, cleared on reset and on load start, and updated in the same cycle as im_we.
REQ-035 SHALL, without IMEM_LOADER_CHECKSUM_EN, have no checksum port and no checksum logic.

Verification
REQ-036 SHALL verify: rst, start, then 3 words 0x20080005, 0x20090003, 0x01095020 (last on the third) -> im_addr 0, 1, 2 with matching im_wdata; word_count=3; core_rst falls 4 cycles after HOLD is entered; done=1.
REQ-037 SHALL verify: in_valid toggled 1,0,1,0 during LOAD -> exactly 2 writes at addresses 0 and 1, with no im_we in the gap cycles.
REQ-038 SHALL verify: with ADDR_W=2, 5 words and no in_last -> 4 writes at addresses 0..3, err=1, the 5th word is not accepted, then RUN.
REQ-039 SHALL verify: rst asserted after the 2nd word -> next cycle IDLE, word_count=0, core_rst=1, im_we=0.
REQ-040 SHALL verify: start pulsed in RUN with 1 word 0xFFFFFFFF -> core_rst=1 the next cycle, a write at address 0, word_count=1.
REQ-041 SHALL verify, with IMEM_LOADER_CHECKSUM_EN, the words 0x0000FFFF and 0xFFFF0000 -> checksum=0xFFFFFFFF.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory while holding the
// core in reset, then releases the core once the load and a short reset-hold
// window have completed.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add a 32-bit XOR
// checksum output covering every word written by the current load.
//
// state | meaning
// IDLE  | after reset, waiting for start; core held in reset
// LOAD  | accepting words and writing them to instruction memory
// HOLD  | load finished; core reset held for the hold window
// RUN   | core released; start triggers a reload

module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_xfer;
  logic                w_clear;
  logic                w_overflow;

  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_word_count;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_err;
  logic                r_im_we;
  logic [ADDR_W-1:0]   r_im_addr;
  logic [31:0]         r_im_wdata;
  logic                r_in_ready;
  logic                r_core_rst;
  logic                r_busy;
  logic                r_done;

  // Next-state decode plus the per-cycle transfer/clear/overflow strobes.
  // HOLD is left on the cycle whose count is 1 (or 0), so the core reset is
  // held for HOLD_CYCLES cycles after the final write, never less than one.
  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_clear     = 1'b0;
    w_overflow  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = LOAD;
          w_clear     = 1'b1;
        end
      end
      LOAD: begin
        w_xfer = in_valid & r_in_ready;
        if (w_xfer) begin
          if (in_last) begin
            w_state_nxt = HOLD;
          end else if (r_addr == ADDR_MAX) begin
            // memory is full and the program has not ended: keep the word
            // just written, flag the overflow and stop accepting
            w_state_nxt = HOLD;
            w_overflow  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (r_hold_cnt <= HOLD_W'(1)) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (start) begin
          w_state_nxt = LOAD;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset takes priority over a coincident start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory write port (one cycle behind the transfer) and load counters.
  // The address counter saturates at the top word instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_im_we      <= 1'b0;
      r_im_addr    <= '0;
      r_im_wdata   <= '0;
      r_addr       <= '0;
      r_word_count <= '0;
    end else begin
      r_im_we <= w_xfer;
      if (w_clear) begin
        r_addr       <= '0;
        r_word_count <= '0;
      end else if (w_xfer) begin
        r_im_addr    <= r_addr;
        r_im_wdata   <= in_data;
        r_word_count <= r_word_count + (ADDR_W+1)'(1);
        if (r_addr != ADDR_MAX) begin
          r_addr <= r_addr + ADDR_W'(1);
        end
      end
    end
  end

  // Sticky overflow flag, cleared only by reset or a new load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_clear) begin
      r_err <= 1'b0;
    end else if (w_overflow) begin
      r_err <= 1'b1;
    end
  end

  // Hold-window down-counter, loaded as LOAD hands over to HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if ((r_state == LOAD) && (w_state_nxt == HOLD)) begin
      r_hold_cnt <= HOLD_INIT;
    end else if ((r_state == HOLD) && (r_hold_cnt != '0)) begin
      r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
    end
  end

  // Status outputs registered from the next state, so they are glitch-free
  // and change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_core_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == LOAD);
      r_core_rst <= (w_state_nxt != RUN);
      r_busy     <= (w_state_nxt == LOAD) || (w_state_nxt == HOLD);
      r_done     <= (w_state_nxt == RUN);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running XOR of written words; steps on the same edge that raises im_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_clear) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum ^ in_data;
    end
  end

  assign checksum = r_checksum;
`endif

  assign in_ready   = r_in_ready;
  assign im_we      = r_im_we;
  assign im_addr    = r_im_addr;
  assign im_wdata   = r_im_wdata;
  assign core_rst   = r_core_rst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_word_count;

endmodule
